// File: rtl/mem_block_initiator.sv
// -----------------------------------------------------------------------------
// mem_block_initiator
//
// Master-side driver for a single-port word RAM with a registered read port.
// On command it either FILLs a block of words with the arithmetic pattern
// seed + k*incr, or CHECKs a block against that same pattern. A CHECK counts
// mismatches (saturating) and records the byte address of the first one.
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_ready is high only when idle
//   cmd_op            0 = FILL, 1 = CHECK
//   cmd_base          byte start address (bits [1:0] forced to zero)
//   cmd_count         number of words; 0 completes immediately
//   cmd_seed/incr     pattern word k = seed + k*incr (mod 2^32)
//   mem_we/addr/din   RAM write enable, byte address and write data
//   mem_dout          RAM read data, valid the cycle after mem_addr
//   busy              operation in progress
//   done              one-cycle pulse when an operation finishes
//   err_count         CHECK mismatch count, saturating
//   err_addr          byte address of the first mismatch of the last CHECK
//   err_seen          at least one mismatch in the last CHECK
// -----------------------------------------------------------------------------
module mem_block_initiator #(
    parameter int CNT_W       = 16,
    parameter int ADDR_STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [31:0]      cmd_base,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [31:0]      cmd_seed,
    input  logic [31:0]      cmd_incr,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    input  logic [31:0]      mem_dout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      err_addr,
    output logic             err_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;

    logic [CNT_W-1:0] remain;     // words still to issue after the current one
    logic [31:0]      incr_r;
    logic [31:0]      pat;        // expected value of the word being read
    logic             cmp_valid;  // a read issued last cycle is due for compare
    logic [31:0]      cmp_addr;
    logic [31:0]      cmp_data;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and status decode
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        last      = (remain == '0);

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_count == '0) begin
                        state_nxt = S_FIN;
                    end else if (cmd_op) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_FIN;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address/data generation, read pipeline and error capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            remain    <= '0;
            incr_r    <= '0;
            pat       <= '0;
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            cmp_data  <= '0;
            err_count <= '0;
            err_addr  <= '0;
            err_seen  <= 1'b0;
        end else begin
            // Writes and compares are single-cycle events unless re-armed below.
            mem_we    <= 1'b0;
            cmp_valid <= 1'b0;

            if (accept) begin
                remain <= cmd_count - CNT_W'(1);
                incr_r <= cmd_incr;
                // A zero-length command leaves the bus exactly as it was.
                if (cmd_count != '0) begin
                    mem_addr <= cmd_base & ~32'h3;
                    if (cmd_op) begin
                        pat <= cmd_seed;
                    end else begin
                        mem_we  <= 1'b1;
                        mem_din <= cmd_seed;
                    end
                end
                if (cmd_op) begin
                    err_count <= '0;
                    err_addr  <= '0;
                    err_seen  <= 1'b0;
                end
            end

            if (state == S_FILL && !last) begin
                mem_we   <= 1'b1;
                mem_addr <= mem_addr + STRIDE;
                mem_din  <= mem_din + incr_r;
                remain   <= remain - CNT_W'(1);
            end

            // The read issued this cycle returns next cycle, so its expected
            // value and address travel one stage behind the bus.
            if (state == S_CHECK) begin
                cmp_valid <= 1'b1;
                cmp_addr  <= mem_addr;
                cmp_data  <= pat;
                if (!last) begin
                    mem_addr <= mem_addr + STRIDE;
                    pat      <= pat + incr_r;
                    remain   <= remain - CNT_W'(1);
                end
            end

            if (cmp_valid && (mem_dout != cmp_data)) begin
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (!err_seen) begin
                    err_seen <= 1'b1;
                    err_addr <= cmp_addr;
                end
            end
        end
    end

endmodule
